oram_request_arbiter: RTL and testbench
=======================================

# oram_request_arbiter

Two-requester arbiter that shares the single front-end port of `TinyORAMCore` (command, write-data and read-data channels) between two clients, e.g. `TrafficGen` and a second host port. A grant is held for a whole ORAM transaction: command handshake, then exactly one block of data beats in the direction the command implies. Grants alternate round-robin so neither client can starve the other. The block sits between the clients and the ORAM core in the board top, in the `ORAMClock` domain.

## Interface

Parameters:
- `ORAMB`, 512, block size in bits
- `ORAMU`, 32, program-address width
- `FEDWidth`, 64, front-end data width; `ORAMB` must be a multiple of `FEDWidth`
- `BECMDWidth`, 2, command width; `Cmd[1]`=1 is a read-type command (ORAM returns data), `Cmd[1]`=0 is a write-type command (client supplies data)

Ports (`Rn_*` exists for n = 0 and 1):
- `Clock`  in  1  single clock
- `Reset`  in  1  asynchronous, active-high reset
- `Rn_Cmd`  in  BECMDWidth  client command
- `Rn_PAddr`  in  ORAMU  client address
- `Rn_CmdValid` / `Rn_CmdReady`  in/out  1  client command handshake
- `Rn_DataIn`  in  FEDWidth  client write data
- `Rn_DataInValid` / `Rn_DataInReady`  in/out  1  write-data handshake
- `Rn_DataOut`  out  FEDWidth  read data (`ORAMDataOut`, broadcast to both clients)
- `Rn_DataOutValid` / `Rn_DataOutReady`  out/in  1  read-data handshake
- `ORAMCommand`, `ORAMPAddr`, `ORAMCommandValid`  out  BECMDWidth/ORAMU/1  command to the core
- `ORAMCommandReady`  in  1
- `ORAMDataIn`, `ORAMDataInValid`  out  FEDWidth/1; `ORAMDataInReady`  in  1
- `ORAMDataOut`, `ORAMDataOutValid`  in  FEDWidth/1; `ORAMDataOutReady`  out  1
- `Grant`  out  2  one-hot registered grant; 0 when idle
- `Busy`  out  1  state ≠ IDLE

## Operation

- `Beats` = ORAMB/FEDWidth (8 at defaults). The beat counter has width `log2(Beats)`, or 1 bit minimum.
- Registers: `state` ∈ {IDLE, CMD, WDATA, RDATA}, `grant` (2 bits, one-hot), `prio` (1 bit, the requester favoured on a tie), beat counter.
- IDLE:
  - All client readies are 0 and all ORAM valids are 0.
  - If any `Rn_CmdValid` is high, latch `grant`. If exactly one requests, grant it. If both request, grant `prio`.
  - Go to CMD.
- CMD:
  - The granted client's Cmd, PAddr and CmdValid drive the ORAM side through a mux selected by the registered `grant`.
  - `Rg_CmdReady` = `ORAMCommandReady`. The other client's ready is 0.
  - On handshake: if `Cmd[1]`=0 go to WDATA, else go to RDATA. Clear the counter.
  - If the granted `CmdValid` drops before the handshake, return to IDLE with no transaction. `prio` is unchanged.
- WDATA:
  - `ORAMDataIn`/`ORAMDataInValid` come from the granted client. `Rg_DataInReady` = `ORAMDataInReady`.
  - Each handshake increments the counter.
  - On the handshake with counter = Beats−1: go to IDLE, `prio` ← non-granted index, `grant` ← 0.
- RDATA:
  - `Rg_DataOutValid` = `ORAMDataOutValid`, and `ORAMDataOutReady` = `Rg_DataOutReady`. The non-granted `DataOutValid` is 0.
  - Counting and the exit to IDLE follow the same rule as WDATA.
- In every state, ungranted readies and valids are 0. Data and payload buses may carry don't-care values while their valid is low.
- Stray `ORAMDataOutValid` outside RDATA: `ORAMDataOutReady` stays 0 (held off, not dropped).

## Timing

- Reset (asynchronous, takes effect immediately): state=IDLE, grant=0, prio=0, counter=0. All valids, readies, `Grant` and `Busy` are 0.
- Reset mid-transaction aborts the transaction. No partial-beat recovery.
- All handshake paths are combinational through the mux, from registered `grant` only. There is no combinational path from `Rn_CmdValid` to the ORAM side.
- Arbitration latency: a request first seen in IDLE at cycle t produces `ORAMCommandValid` at t+1.
- Back-to-back transactions: at least one IDLE cycle separates the last data beat from the next command.
- Write transaction duration, with no stalls: 1 (IDLE) + 1 (CMD) + Beats cycles.
- Simultaneous requests always resolve by `prio`. A lone requester is served repeatedly regardless of `prio`.
- Backpressure on either side can stall any beat indefinitely. The counter advances only on valid&&ready.

## Test plan

- Reset, then R0 sends a write (Cmd=2'b00, PAddr=0x10) with 8 beats 0..7. Required: ORAM sees the command at cycle t+1, then beats 0..7 in order. `Grant`=01 throughout. Return to IDLE, `prio`=1.
- R0 and R1 both assert read commands (Cmd=2'b10) on the same cycle after reset. Required: R0 is served first. The 8 ORAM beats go only to `R0_DataOutValid`. Then R1 is granted, and `R1_DataOutValid` sees the next 8 beats.
- R1 issues 3 consecutive writes while R0 stays idle. Required: all 3 are granted to R1, with exactly one IDLE cycle between them.
- R0 write with `ORAMDataInReady` toggling 1/0 every cycle. Required: 8 transfers complete in 16 data cycles, and no beat is duplicated or dropped.
- Assert `Reset` during beat 4 of an R1 read. Required: all outputs are 0 in the same cycle. After release, R0's request is granted first (`prio`=0).
- R0 drops `CmdValid` in CMD while `ORAMCommandReady`=0. Required: return to IDLE, no ORAM command handshake occurs, and `prio` is unchanged.

Source files
------------

// File: rtl/oram_request_arbiter_if.sv
// One TinyORAM front-end port: command, write-data and read-data channels.
// The master side issues commands and write data and consumes read data.
interface oram_request_arbiter_if #(
  parameter int ORAMU      = 32,
  parameter int FEDWidth   = 64,
  parameter int BECMDWidth = 2
);
  logic [BECMDWidth-1:0] Cmd;
  logic [ORAMU-1:0]      PAddr;
  logic                  CmdValid;
  logic                  CmdReady;
  logic [FEDWidth-1:0]   DataIn;
  logic                  DataInValid;
  logic                  DataInReady;
  logic [FEDWidth-1:0]   DataOut;
  logic                  DataOutValid;
  logic                  DataOutReady;

  modport master (
    output Cmd, PAddr, CmdValid, DataIn, DataInValid, DataOutReady,
    input  CmdReady, DataInReady, DataOut, DataOutValid
  );

  modport slave (
    input  Cmd, PAddr, CmdValid, DataIn, DataInValid, DataOutReady,
    output CmdReady, DataInReady, DataOut, DataOutValid
  );
endinterface

// File: rtl/oram_request_arbiter.sv
// Round-robin arbiter sharing one TinyORAM front-end port between two clients.
// A grant covers a whole transaction: command handshake plus one block of beats.
module oram_request_arbiter #(
  parameter int ORAMB      = 512,
  parameter int ORAMU      = 32,
  parameter int FEDWidth   = 64,
  parameter int BECMDWidth = 2
) (
  input  logic                          Clock,
  input  logic                          Reset,
  oram_request_arbiter_if.slave         r0,
  oram_request_arbiter_if.slave         r1,
  oram_request_arbiter_if.master        oram,
  output logic [1:0]                    Grant,
  output logic                          Busy
);

  localparam int Beats = ORAMB / FEDWidth;
  localparam int CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  state_t          state;
  logic [1:0]      grant;
  logic            prio;
  logic [CntW-1:0] beat_cnt;

  logic g_cmd_valid;
  logic g_rd_cmd;
  logic g_din_valid;
  logic g_dout_ready;
  logic in_cmd;
  logic in_wdata;
  logic in_rdata;
  logic beat_hs;

  assign in_cmd   = (state == CMD);
  assign in_wdata = (state == WDATA);
  assign in_rdata = (state == RDATA);

  // AND-OR mux keyed on the registered one-hot grant; all zero when idle
  assign g_cmd_valid  = (grant[0] & r0.CmdValid)     | (grant[1] & r1.CmdValid);
  assign g_rd_cmd     = (grant[0] & r0.Cmd[1])       | (grant[1] & r1.Cmd[1]);
  assign g_din_valid  = (grant[0] & r0.DataInValid)  | (grant[1] & r1.DataInValid);
  assign g_dout_ready = (grant[0] & r0.DataOutReady) | (grant[1] & r1.DataOutReady);

  assign oram.Cmd      = ({BECMDWidth{grant[0]}} & r0.Cmd)    | ({BECMDWidth{grant[1]}} & r1.Cmd);
  assign oram.PAddr    = ({ORAMU{grant[0]}}      & r0.PAddr)  | ({ORAMU{grant[1]}}      & r1.PAddr);
  assign oram.DataIn   = ({FEDWidth{grant[0]}}   & r0.DataIn) | ({FEDWidth{grant[1]}}   & r1.DataIn);

  assign oram.CmdValid     = in_cmd   & g_cmd_valid;
  assign oram.DataInValid  = in_wdata & g_din_valid;
  // a stray read beat outside RDATA is held off, never consumed
  assign oram.DataOutReady = in_rdata & g_dout_ready;

  assign r0.CmdReady     = in_cmd   & grant[0] & oram.CmdReady;
  assign r1.CmdReady     = in_cmd   & grant[1] & oram.CmdReady;
  assign r0.DataInReady  = in_wdata & grant[0] & oram.DataInReady;
  assign r1.DataInReady  = in_wdata & grant[1] & oram.DataInReady;
  assign r0.DataOutValid = in_rdata & grant[0] & oram.DataOutValid;
  assign r1.DataOutValid = in_rdata & grant[1] & oram.DataOutValid;
  assign r0.DataOut      = oram.DataOut;
  assign r1.DataOut      = oram.DataOut;

  assign beat_hs = (oram.DataInValid & oram.DataInReady) |
                   (oram.DataOutValid & oram.DataOutReady);

  assign Grant = grant;
  assign Busy  = (state != IDLE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      grant    <= 2'b00;
      prio     <= 1'b0;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (r0.CmdValid || r1.CmdValid) begin
            state <= CMD;
            if (r0.CmdValid && r1.CmdValid) grant <= prio ? 2'b10 : 2'b01;
            else                            grant <= r1.CmdValid ? 2'b10 : 2'b01;
          end
        end
        CMD: begin
          if (!g_cmd_valid) begin
            // requester withdrew: no transaction, fairness state untouched
            state <= IDLE;
            grant <= 2'b00;
          end else if (oram.CmdReady) begin
            state    <= g_rd_cmd ? RDATA : WDATA;
            beat_cnt <= '0;
          end
        end
        WDATA, RDATA: begin
          if (beat_hs) begin
            beat_cnt <= beat_cnt + CntW'(1);
            if (beat_cnt == LastBeat) begin
              state    <= IDLE;
              grant    <= 2'b00;
              prio     <= grant[0];
              beat_cnt <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oram_request_arbiter.sv
// Scoreboard bench for oram_request_arbiter: client and ORAM behaviour models
// drive traffic; expected commands and beats are queued up front and popped on handshakes.
module tb_oram_request_arbiter;
  localparam int ORAMB      = 512;
  localparam int ORAMU      = 32;
  localparam int FEDWidth   = 64;
  localparam int BECMDWidth = 2;
  localparam int BEATS      = ORAMB / FEDWidth;

  logic       Clock;
  logic       Reset;
  logic [1:0] Grant;
  logic       Busy;

  oram_request_arbiter_if #(.ORAMU(ORAMU), .FEDWidth(FEDWidth), .BECMDWidth(BECMDWidth)) r0 ();
  oram_request_arbiter_if #(.ORAMU(ORAMU), .FEDWidth(FEDWidth), .BECMDWidth(BECMDWidth)) r1 ();
  oram_request_arbiter_if #(.ORAMU(ORAMU), .FEDWidth(FEDWidth), .BECMDWidth(BECMDWidth)) oram ();

  oram_request_arbiter #(
    .ORAMB(ORAMB), .ORAMU(ORAMU), .FEDWidth(FEDWidth), .BECMDWidth(BECMDWidth)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .r0(r0),
    .r1(r1),
    .oram(oram),
    .Grant(Grant),
    .Busy(Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [1:0]            grant;
    logic [BECMDWidth-1:0] cmd;
    logic [ORAMU-1:0]      addr;
  } cmd_t;

  typedef struct packed {
    logic                cl;
    logic [FEDWidth-1:0] data;
  } rd_t;

  cmd_t                exp_cmd[$];
  logic [FEDWidth-1:0] exp_w[$];
  rd_t                 exp_r[$];

  int vectors = 0;
  int errors  = 0;

  bit                    req_on[2];
  logic [BECMDWidth-1:0] req_cmd[2];
  logic [ORAMU-1:0]      req_addr[2];
  int                    wr_left[2];
  logic [FEDWidth-1:0]   wr_data[2];
  int                    rep_left[2];
  int                    wbeats[2];
  int                    rbeats[2];
  int                    rd_left;
  logic [FEDWidth-1:0]   rd_data;
  bit cmd_ready, tog_mode, rd_tog, tog, stray;

  task automatic flush();
    exp_cmd.delete();
    exp_w.delete();
    exp_r.delete();
    for (int c = 0; c < 2; c++) begin
      req_on[c] = 1'b0; req_cmd[c] = '0; req_addr[c] = '0;
      wr_left[c] = 0; wr_data[c] = '0; rep_left[c] = 0;
      wbeats[c] = 0; rbeats[c] = 0;
    end
    rd_left = 0; rd_data = '0;
    cmd_ready = 1'b1; tog_mode = 1'b0; rd_tog = 1'b0; tog = 1'b0; stray = 1'b0;
  endtask

  task automatic drive();
    r0.CmdValid     = req_on[0];
    r0.Cmd          = req_cmd[0];
    r0.PAddr        = req_addr[0];
    r0.DataInValid  = (wr_left[0] > 0);
    r0.DataIn       = wr_data[0];
    r0.DataOutReady = 1'b1;
    r1.CmdValid     = req_on[1];
    r1.Cmd          = req_cmd[1];
    r1.PAddr        = req_addr[1];
    r1.DataInValid  = (wr_left[1] > 0);
    r1.DataIn       = wr_data[1];
    r1.DataOutReady = rd_tog ? tog : 1'b1;
    oram.CmdReady     = cmd_ready;
    oram.DataInReady  = tog_mode ? tog : 1'b1;
    oram.DataOutValid = (rd_left > 0) || stray;
    oram.DataOut      = rd_data;
  endtask

  task automatic observe();
    cmd_t                ec;
    rd_t                 er;
    logic [FEDWidth-1:0] ew;
    bit                  cmd_hs;
    cmd_hs = oram.CmdValid && oram.CmdReady;
    if (cmd_hs) begin
      vectors++;
      if (exp_cmd.size() == 0) begin
        errors++;
        $display("FAIL cmd_unexpected: got grant=%b cmd=%b addr=%h, want no command", Grant, oram.Cmd, oram.PAddr);
      end else begin
        ec = exp_cmd.pop_front();
        if ({Grant, oram.Cmd, oram.PAddr} !== ec) begin
          errors++;
          $display("FAIL cmd: got grant=%b cmd=%b addr=%h, want grant=%b cmd=%b addr=%h",
                   Grant, oram.Cmd, oram.PAddr, ec.grant, ec.cmd, ec.addr);
        end
      end
      if (oram.Cmd[1]) rd_left = BEATS;
    end
    if (r0.CmdValid && r0.CmdReady) begin
      req_on[0] = 1'b0;
      if (!req_cmd[0][1]) wr_left[0] = BEATS;
    end
    if (r1.CmdValid && r1.CmdReady) begin
      req_on[1] = 1'b0;
      if (!req_cmd[1][1]) wr_left[1] = BEATS;
    end
    if (oram.DataInValid && oram.DataInReady) begin
      vectors++;
      if (exp_w.size() == 0) begin
        errors++;
        $display("FAIL wbeat_unexpected: got %h, want no write beat", oram.DataIn);
      end else begin
        ew = exp_w.pop_front();
        if (oram.DataIn !== ew) begin
          errors++;
          $display("FAIL wbeat: got %h, want %h", oram.DataIn, ew);
        end
      end
    end
    for (int c = 0; c < 2; c++) begin
      if ((c == 0) ? (r0.DataInValid && r0.DataInReady) : (r1.DataInValid && r1.DataInReady)) begin
        wr_left[c]--; wr_data[c]++; wbeats[c]++;
        if (wr_left[c] == 0 && rep_left[c] > 0) begin
          rep_left[c]--;
          req_on[c] = 1'b1;
        end
      end
    end
    if (r0.DataOutValid && r0.DataOutReady) begin
      vectors++;
      if (exp_r.size() == 0) begin
        errors++;
        $display("FAIL rbeat_unexpected: R0 got %h, want no read beat", r0.DataOut);
      end else begin
        er = exp_r.pop_front();
        if ({1'b0, r0.DataOut} !== er) begin
          errors++;
          $display("FAIL rbeat: client 0 got %h, want client %0d data %h", r0.DataOut, er.cl, er.data);
        end
      end
      rbeats[0]++;
    end
    if (r1.DataOutValid && r1.DataOutReady) begin
      vectors++;
      if (exp_r.size() == 0) begin
        errors++;
        $display("FAIL rbeat_unexpected: R1 got %h, want no read beat", r1.DataOut);
      end else begin
        er = exp_r.pop_front();
        if ({1'b1, r1.DataOut} !== er) begin
          errors++;
          $display("FAIL rbeat: client 1 got %h, want client %0d data %h", r1.DataOut, er.cl, er.data);
        end
      end
      rbeats[1]++;
    end
    vectors++;
    if (!$onehot0(Grant) || (r0.DataOutValid && r1.DataOutValid) ||
        (oram.DataOutReady && rd_left == 0)) begin
      errors++;
      $display("FAIL invariant: grant=%b r0_dov=%b r1_dov=%b oram_dor=%b reads_pending=%0d, want onehot0 grant, one read sink, no stray accept",
               Grant, r0.DataOutValid, r1.DataOutValid, oram.DataOutReady, rd_left);
    end
    if (oram.DataOutValid && oram.DataOutReady && rd_left > 0) begin
      rd_left--;
      rd_data++;
    end
    tog = cmd_hs ? 1'b0 : ~tog;
  endtask

  task automatic step();
    @(negedge Clock);
    drive();
    #1;
    observe();
  endtask

  function automatic bit done();
    return !Busy && !req_on[0] && !req_on[1] && wr_left[0] == 0 && wr_left[1] == 0 &&
           rd_left == 0 && exp_cmd.size() == 0 && exp_w.size() == 0 && exp_r.size() == 0;
  endfunction

  function automatic logic [12:0] quiet_bits();
    return {Grant, Busy, oram.CmdValid, oram.DataInValid, oram.DataOutReady,
            r0.CmdReady, r1.CmdReady, r0.DataInReady, r1.DataInReady,
            r0.DataOutValid, r1.DataOutValid, dut.prio};
  endfunction

  task automatic do_reset();
    flush();
    Reset = 1'b1;
    @(negedge Clock); drive();
    @(negedge Clock); drive();
    Reset = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input string name);
    int n = 0;
    while (!done() && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (!done()) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b cmds_left=%0d wbeats_left=%0d rbeats_left=%0d after %0d cycles, want drained",
               name, Busy, exp_cmd.size(), exp_w.size(), exp_r.size(), n);
      do_reset();
    end
  endtask

  task automatic issue(input int c, input logic [1:0] cmd, input logic [ORAMU-1:0] addr,
                       input logic [FEDWidth-1:0] base);
    req_on[c] = 1'b1; req_cmd[c] = cmd; req_addr[c] = addr; wr_data[c] = base;
  endtask

  task automatic push_writes(input logic [FEDWidth-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_w.push_back(base + FEDWidth'(i));
  endtask

  task automatic push_reads(input logic cl, input logic [FEDWidth-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_r.push_back({cl, base + FEDWidth'(i)});
  endtask

  task automatic test_reset();
    flush();
    req_on[0] = 1'b1; req_on[1] = 1'b1; stray = 1'b1;
    Reset = 1'b1;
    @(negedge Clock); drive();
    @(negedge Clock); drive();
    #1;
    vectors++;
    if (quiet_bits() !== 13'd0) begin
      errors++;
      $display("FAIL reset_quiet: got %b, want all zero", quiet_bits());
    end
    flush();
    @(negedge Clock); drive();
    Reset = 1'b0;
  endtask

  task automatic test_single_write();
    int busy_cyc = 0;
    int bad_grant = 0;
    int n = 0;
    exp_cmd.push_back({2'b01, 2'b00, 32'h10});
    push_writes(64'h0, BEATS);
    issue(0, 2'b00, 32'h10, 64'h0);
    step();
    vectors++;
    if ({oram.CmdValid, Busy} !== 2'b00) begin
      errors++;
      $display("FAIL arb_cycle_t: got cmd_valid=%b busy=%b, want 0 0", oram.CmdValid, Busy);
    end
    step();
    vectors++;
    if ({oram.CmdValid, Grant} !== 3'b101) begin
      errors++;
      $display("FAIL arb_cycle_t1: got cmd_valid=%b grant=%b, want 1 01", oram.CmdValid, Grant);
    end
    busy_cyc = 1;
    while (Busy && n < 50) begin
      step();
      n++;
      if (Busy) begin
        busy_cyc++;
        if (Grant !== 2'b01) bad_grant++;
      end
    end
    vectors++;
    if (busy_cyc !== 1 + BEATS || bad_grant !== 0) begin
      errors++;
      $display("FAIL write_duration: got busy=%0d bad_grant=%0d, want busy=%0d bad_grant=0", busy_cyc, bad_grant, 1 + BEATS);
    end
    run_until_done(20, "single_write");
    vectors++;
    if (dut.prio !== 1'b1) begin
      errors++;
      $display("FAIL prio_after_r0: got %b, want 1", dut.prio);
    end
  endtask

  task automatic test_both_read();
    do_reset();
    rd_data = 64'hA000;
    rd_tog = 1'b1;
    exp_cmd.push_back({2'b01, 2'b10, 32'h40});
    exp_cmd.push_back({2'b10, 2'b10, 32'h80});
    push_reads(1'b0, 64'hA000, BEATS);
    push_reads(1'b1, 64'hA000 + BEATS, BEATS);
    issue(0, 2'b10, 32'h40, 64'h0);
    issue(1, 2'b10, 32'h80, 64'h0);
    run_until_done(200, "both_read");
    vectors++;
    if (rbeats[0] !== BEATS || rbeats[1] !== BEATS || dut.prio !== 1'b0) begin
      errors++;
      $display("FAIL both_read_counts: got r0=%0d r1=%0d prio=%b, want %0d %0d 0", rbeats[0], rbeats[1], dut.prio, BEATS, BEATS);
    end
    rd_tog = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    int gaps = 0;
    int bad_grant = 0;
    int n = 0;
    wbeats[1] = 0;
    for (int i = 0; i < 3; i++) exp_cmd.push_back({2'b10, 2'b00, 32'h20});
    push_writes(64'h100, 3 * BEATS);
    rep_left[1] = 2;
    issue(1, 2'b00, 32'h20, 64'h100);
    while (!done() && n < 200) begin
      step();
      n++;
      if (Busy) begin
        seen = 1'b1;
        if (Grant !== 2'b10) bad_grant++;
      end else if (seen && !done()) begin
        gaps++;
      end
    end
    run_until_done(10, "back_to_back");
    vectors++;
    if (gaps !== 2 || bad_grant !== 0 || wbeats[1] !== 3 * BEATS) begin
      errors++;
      $display("FAIL back_to_back: got idle_gaps=%0d bad_grant=%0d beats=%0d, want 2 0 %0d", gaps, bad_grant, wbeats[1], 3 * BEATS);
    end
  endtask

  task automatic test_ready_toggle();
    int offered = 0;
    int n = 0;
    tog_mode = 1'b1;
    exp_cmd.push_back({2'b01, 2'b00, 32'h30});
    push_writes(64'h200, BEATS);
    issue(0, 2'b00, 32'h30, 64'h200);
    while (!done() && n < 100) begin
      step();
      n++;
      if (r0.DataInValid) offered++;
    end
    run_until_done(10, "ready_toggle");
    vectors++;
    if (offered !== 2 * BEATS) begin
      errors++;
      $display("FAIL ready_toggle_cycles: got %0d, want %0d", offered, 2 * BEATS);
    end
    tog_mode = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    rd_data = 64'hB000;
    rbeats[1] = 0;
    exp_cmd.push_back({2'b10, 2'b10, 32'h50});
    push_reads(1'b1, 64'hB000, BEATS);
    issue(1, 2'b10, 32'h50, 64'h0);
    while (rbeats[1] < 4 && n < 50) begin
      step();
      n++;
    end
    vectors++;
    if (rbeats[1] !== 4 || Grant !== 2'b10) begin
      errors++;
      $display("FAIL reset_mid_setup: got beats=%0d grant=%b, want 4 10", rbeats[1], Grant);
    end
    @(negedge Clock);
    drive();
    Reset = 1'b1;
    #1;
    vectors++;
    if (quiet_bits() !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got %b, want all zero", quiet_bits());
    end
    flush();
    @(negedge Clock); drive();
    Reset = 1'b0;
    exp_cmd.push_back({2'b01, 2'b00, 32'h60});
    exp_cmd.push_back({2'b10, 2'b00, 32'h70});
    push_writes(64'h300, BEATS);
    push_writes(64'h400, BEATS);
    issue(0, 2'b00, 32'h60, 64'h300);
    issue(1, 2'b00, 32'h70, 64'h400);
    run_until_done(100, "after_reset");
  endtask

  task automatic test_cmd_drop();
    cmd_ready = 1'b0;
    issue(0, 2'b00, 32'h90, 64'h500);
    step();
    step();
    vectors++;
    if ({oram.CmdValid, r0.CmdReady, Grant} !== 4'b1001) begin
      errors++;
      $display("FAIL cmd_stall: got valid=%b ready=%b grant=%b, want 1 0 01", oram.CmdValid, r0.CmdReady, Grant);
    end
    req_on[0] = 1'b0;
    stray = 1'b1;
    step();
    vectors++;
    if ({oram.CmdValid, oram.DataOutReady, r0.DataOutValid, r1.DataOutValid} !== 4'b0000) begin
      errors++;
      $display("FAIL cmd_drop: got valid=%b dor=%b dov=%b%b, want 0000", oram.CmdValid, oram.DataOutReady, r0.DataOutValid, r1.DataOutValid);
    end
    step();
    vectors++;
    if ({Busy, Grant, dut.prio, oram.DataOutReady} !== 5'b00000) begin
      errors++;
      $display("FAIL cmd_drop_idle: got busy=%b grant=%b prio=%b dor=%b, want 0 00 0 0", Busy, Grant, dut.prio, oram.DataOutReady);
    end
    stray = 1'b0;
    cmd_ready = 1'b1;
    exp_cmd.push_back({2'b01, 2'b00, 32'h90});
    push_writes(64'h500, BEATS);
    issue(0, 2'b00, 32'h90, 64'h500);
    run_until_done(50, "after_drop");
  endtask

  initial begin
    Reset = 1'b1;
    flush();
    drive();
    test_reset();
    test_single_write();
    test_both_read();
    test_back_to_back();
    test_ready_toggle();
    test_reset_mid();
    test_cmd_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
